spi_slave_responder: RTL and testbench

- Synthesizable SPI mode-0 slave, MSB-first.
- Sits at the far end of the processor's SPI peripheral pins (SCK, MOSI, MISO).
- Deserializes the master's MOSI bytes and serializes response bytes onto MISO from a single-entry transmit buffer.
- Used on the bench as the SPI target, and on-chip/FPGA as a loopback/companion device. The pin set has no chip-select, so byte framing uses an SCK idle timeout.

---
 rtl/spi_slave_responder_pkg.sv | 12 +
 rtl/spi_slave_responder_sync_edge_detect.sv | 31 +++
 rtl/spi_slave_responder.sv | 164 ++++++++++++++++
 tb/tb_spi_slave_responder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_responder_pkg.sv
// Shared defaults and state encoding for the SPI mode-0 slave responder.
package spi_slave_responder_pkg;

    localparam logic [7:0] SPI_RESP_DEFAULT_TX   = 8'hFF;
    localparam int         SPI_RESP_IDLE_TIMEOUT = 64;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/spi_slave_responder_sync_edge_detect.sv
// Two-flop synchronizer with a delay flop; reports the synchronized level and its edges.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            d  <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            d  <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~d;
    assign fall  = ~s2 & d;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave, MSB-first, single-entry transmit buffer; bytes are framed by an SCK idle timeout.
//   state  | meaning
//   IDLE   | between bytes; miso shows MSB of buffered byte or DEFAULT_TX
//   ACTIVE | mid-byte; shifting on SCK edges, timeout counter running
module spi_slave_responder
    import spi_slave_responder_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_TX   = DATA_WIDTH'(SPI_RESP_DEFAULT_TX),
    parameter int                    IDLE_TIMEOUT = SPI_RESP_IDLE_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sck,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_error,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);

    logic sck_level_unused;
    logic sck_rise;
    logic sck_fall;
    logic mosi_s1;
    logic mosi_s2;

    state_t                state,     state_n;
    logic [CW-1:0]         bit_cnt,   bit_cnt_n;
    logic [TW-1:0]         tmo_cnt,   tmo_cnt_n;
    logic [DATA_WIDTH-1:0] shift_in,  shift_in_n;
    logic [DATA_WIDTH-1:0] shift_out, shift_out_n;
    logic [DATA_WIDTH-1:0] tx_buf,    tx_buf_n;
    logic                  tx_full,   tx_full_n;
    logic [DATA_WIDTH-1:0] rx_data_n;
    logic                  rx_valid_n;
    logic                  frame_error_n;
    logic                  tx_consume;
    logic                  tx_write;
    logic [DATA_WIDTH-1:0] idle_word;

    sync_edge_detect u_sck_sync (
        .clk   (clk),
        .reset (reset),
        .din   (sck),
        .level (sck_level_unused),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            mosi_s1 <= mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    // Write acceptance looks at tx_full before this cycle's consume.
    assign tx_write  = tx_valid & ~tx_full;
    assign idle_word = tx_full ? tx_buf : DEFAULT_TX;
    assign miso      = (state == ST_IDLE) ? idle_word[DATA_WIDTH-1] : shift_out[DATA_WIDTH-1];
    assign tx_ready  = ~tx_full;
    assign busy      = (state == ST_ACTIVE);

    always_comb begin
        state_n       = state;
        bit_cnt_n     = bit_cnt;
        tmo_cnt_n     = tmo_cnt;
        shift_in_n    = shift_in;
        shift_out_n   = shift_out;
        rx_data_n     = rx_data;
        rx_valid_n    = 1'b0;
        frame_error_n = 1'b0;
        tx_consume    = 1'b0;

        case (state)
            ST_IDLE: begin
                tmo_cnt_n = '0;
                if (sck_rise) begin
                    shift_in_n  = {shift_in[DATA_WIDTH-2:0], mosi_s2};
                    shift_out_n = idle_word;
                    bit_cnt_n   = CW'(1);
                    tx_consume  = tx_full;
                    state_n     = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (sck_rise) begin
                    tmo_cnt_n  = '0;
                    shift_in_n = {shift_in[DATA_WIDTH-2:0], mosi_s2};
                    if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
                        rx_data_n  = {shift_in[DATA_WIDTH-2:0], mosi_s2};
                        rx_valid_n = 1'b1;
                        bit_cnt_n  = '0;
                        state_n    = ST_IDLE;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end else if (sck_fall) begin
                    tmo_cnt_n   = '0;
                    shift_out_n = shift_out << 1;
                end else if (tmo_cnt == TW'(IDLE_TIMEOUT - 1)) begin
                    // Abandoned byte: the consumed buffer entry is not restored.
                    tmo_cnt_n     = '0;
                    bit_cnt_n     = '0;
                    shift_in_n    = '0;
                    frame_error_n = 1'b1;
                    state_n       = ST_IDLE;
                end else begin
                    tmo_cnt_n = tmo_cnt + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_full_n = tx_full;
        tx_buf_n  = tx_buf;
        if (tx_write) begin
            tx_full_n = 1'b1;
            tx_buf_n  = tx_data;
        end else if (tx_consume) begin
            tx_full_n = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            tmo_cnt     <= '0;
            shift_in    <= '0;
            shift_out   <= '0;
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            tmo_cnt     <= tmo_cnt_n;
            shift_in    <= shift_in_n;
            shift_out   <= shift_out_n;
            tx_buf      <= tx_buf_n;
            tx_full     <= tx_full_n;
            rx_data     <= rx_data_n;
            rx_valid    <= rx_valid_n;
            frame_error <= frame_error_n;
        end
    end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Scoreboard bench for spi_slave_responder: a behavioural master plus a transmit-buffer model.
module tb_spi_slave_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sck = 1'b0;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_error;
    logic       busy;

    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] exp_rx[$];
    int         exp_fe = 0;
    bit         model_full = 1'b0;
    logic [7:0] model_buf = 8'h00;

    always #5 clk = ~clk;

    spi_slave_responder dut (
        .clk         (clk),
        .reset       (reset),
        .sck         (sck),
        .mosi        (mosi),
        .miso        (miso),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every received byte or frame error must match an expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && rx_valid) begin
                if (exp_rx.size() == 0) check("rx_valid_unexpected", rx_valid, 1'b0);
                else check("rx_data", rx_data, exp_rx.pop_front());
            end
            if (!reset && frame_error) begin
                if (exp_fe == 0) check("frame_error_unexpected", frame_error, 1'b0);
                else begin
                    exp_fe--;
                    check("frame_error", frame_error, 1'b1);
                end
            end
        end
    end

    task automatic tx_write(input logic [7:0] b);
        bit acc;
        acc = !model_full;
        check("tx_ready_pre_write", tx_ready, acc);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        if (acc) begin
            model_full = 1'b1;
            model_buf  = b;
        end
    endtask

    // Mode-0 master: mosi changes while sck low, miso sampled just before each rise.
    task automatic master_xfer(input logic [7:0] b, input int nbits, input int h);
        logic [7:0] exp_miso;
        logic [7:0] got;
        exp_miso = model_full ? model_buf : 8'hFF;
        got = 8'h00;
        if (nbits == 8) exp_rx.push_back(b);
        else exp_fe++;
        for (int i = 0; i < nbits; i++) begin
            mosi = b[7-i];
            repeat (h) @(negedge clk);
            got[7-i] = miso;
            sck = 1'b1;
            for (int k = 1; k <= h; k++) begin
                @(negedge clk);
                if (i == 0 && k == 3) model_full = 1'b0;
                if (i == 0 && k == 4) check("tx_ready_after_consume", tx_ready, !model_full);
                if (i == 7 && k == 2) check("rx_valid_early", rx_valid, 1'b0);
                if (i == 7 && k == 3) check("rx_valid_latency", rx_valid, 1'b1);
                if (k == h) check("busy", busy, (i == 7) ? 1'b0 : 1'b1);
            end
            sck = 1'b0;
        end
        if (nbits == 8) check("miso_byte", got, exp_miso);
    endtask

    task automatic wait_timeout();
        int n;
        n = 0;
        while (exp_fe != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("timeout_seen", exp_fe, 0);
        check("timeout_cycles_in_window", (n >= 64 && n <= 72), 1'b1);
        check("busy_after_timeout", busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_miso", miso, 1'b1);
        check("reset_tx_ready", tx_ready, 1'b1);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_busy", busy, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        master_xfer(8'h00, 8, 5);
        repeat (4) @(negedge clk);

        tx_write(8'h3C);
        repeat (2) @(negedge clk);
        master_xfer(8'hA5, 8, 5);
        repeat (4) @(negedge clk);

        // Back-to-back bytes with a reload during the first.
        tx_write(8'h11);
        fork
            begin
                master_xfer(8'h01, 8, 5);
                master_xfer(8'h02, 8, 5);
                master_xfer(8'h03, 8, 5);
            end
            begin
                repeat (11) @(negedge clk);
                tx_write(8'h22);
            end
        join
        repeat (4) @(negedge clk);

        // Timeout then realignment.
        master_xfer(8'hE0, 3, 5);
        wait_timeout();
        master_xfer(8'h5A, 8, 5);
        repeat (4) @(negedge clk);

        // Reset mid-byte with a full buffer.
        master_xfer(8'hB7, 5, 5);
        tx_write(8'h99);
        check("tx_ready_before_reset", tx_ready, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_miso", miso, 1'b1);
        check("async_reset_tx_ready", tx_ready, 1'b1);
        check("async_reset_rx_valid", rx_valid, 1'b0);
        check("async_reset_busy", busy, 1'b0);
        check("async_reset_frame_error", frame_error, 1'b0);
        exp_fe = 0;
        model_full = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        master_xfer(8'hC3, 8, 5);
        repeat (4) @(negedge clk);

        // Write collides with the consume of 0x3C: must be ignored.
        tx_write(8'h3C);
        fork
            master_xfer(8'h12, 8, 5);
            begin
                repeat (7) @(negedge clk);
                tx_write(8'h77);
            end
        join
        repeat (2) @(negedge clk);
        check("tx_ready_after_collision", tx_ready, 1'b1);
        master_xfer(8'h34, 8, 5);
        repeat (4) @(negedge clk);

        // Randomized traffic.
        for (int t = 0; t < 30; t++) begin
            int h;
            h = int'($urandom_range(4, 7));
            if ($urandom_range(0, 1) == 1) tx_write(8'($urandom));
            repeat ($urandom_range(0, 10)) @(negedge clk);
            if ($urandom_range(0, 5) == 0) begin
                master_xfer(8'($urandom), int'($urandom_range(1, 7)), h);
                wait_timeout();
            end else begin
                master_xfer(8'($urandom), 8, h);
            end
        end
        repeat (10) @(negedge clk);
        check("rx_queue_drained", exp_rx.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
